pc_redirect_unit: RTL and testbench

- Fetch-side next-PC stage: owns the fetch PC register and consumes decode-stage branch/jump resolution, including the taken flag from the decode branch comparator.
- Computes branch, jump and jump-register targets.
- Buffers a redirect that arrives while fetch is stalled, and tags the delay-slot instruction as it enters decode.
- Sits between the decode-stage compare/control logic and the instruction-fetch interface.

---
 rtl/pc_redirect_unit_pkg.sv | 22 ++
 rtl/pc_target_calc.sv | 52 +++++
 rtl/pc_redirect_unit.sv | 94 +++++++++
 tb/tb_pc_redirect_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// Shared constants and types for the fetch next-PC stage.
// Used by pc_target_calc and pc_redirect_unit.
package pc_redirect_unit_pkg;

  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    RK_NONE,
    RK_BR,
    RK_J,
    RK_JR
  } redir_kind_e;

  function automatic logic [31:0] br_offset(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational target selection for decode-resolved control flow.
// Priority when several controls are high: jr > j > taken branch.
import pc_redirect_unit_pkg::*;

module pc_target_calc (
  input  logic        branch_d,
  input  logic        branch_taken_d,
  input  logic        jump_d,
  input  logic        jr_d,
  input  logic [31:0] pc_plus4_d,
  input  logic [15:0] imm_d,
  input  logic [25:0] instr_index_d,
  input  logic [31:0] rs_val_d,
  output logic [31:0] target,
  output redir_kind_e kind,
  output logic        taken,
  output logic        is_ctrl
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign br_tgt  = pc_plus4_d + br_offset(imm_d);
  assign j_tgt   = {pc_plus4_d[31:28], instr_index_d, 2'b00};
  assign is_ctrl = branch_d | jump_d | jr_d;
  assign taken   = (kind != RK_NONE);

  // pick the highest-priority redirect source
  always_comb begin
    target = 32'd0;
    kind   = RK_NONE;
    priority case (1'b1)
      jr_d: begin
        target = rs_val_d;
        kind   = RK_JR;
      end
      jump_d: begin
        target = j_tgt;
        kind   = RK_J;
      end
      (branch_d & branch_taken_d): begin
        target = br_tgt;
        kind   = RK_BR;
      end
      default: begin
        target = 32'd0;
        kind   = RK_NONE;
      end
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register, stalled-redirect buffer and delay-slot tag.
// Optional FETCH_ALIGN_CHECK_EN adds fetch_adel_f misalignment flag.
import pc_redirect_unit_pkg::*;

module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = pc_redirect_unit_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP  = pc_redirect_unit_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_exc,
  input  logic [31:0] exc_pc,
  input  logic        branch_d,
  input  logic        branch_taken_d,
  input  logic        jump_d,
  input  logic        jr_d,
  input  logic [31:0] pc_plus4_d,
  input  logic [15:0] imm_d,
  input  logic [25:0] instr_index_d,
  input  logic [31:0] rs_val_d,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_adel_f,
`endif
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        redirect_pending,
  output logic        is_ds_d
);

  logic [31:0] target;
  redir_kind_e kind;
  logic        taken;
  logic        is_ctrl;
  logic        redir_req;
  logic        pending_valid;
  logic [31:0] pending_pc;

  pc_target_calc u_calc (
    .branch_d       (branch_d),
    .branch_taken_d (branch_taken_d),
    .jump_d         (jump_d),
    .jr_d           (jr_d),
    .pc_plus4_d     (pc_plus4_d),
    .imm_d          (imm_d),
    .instr_index_d  (instr_index_d),
    .rs_val_d       (rs_val_d),
    .target         (target),
    .kind           (kind),
    .taken          (taken),
    .is_ctrl        (is_ctrl)
  );

  // a redirect counts only on the cycle decode advances
  assign redir_req        = ~stall_d & taken;
  assign pc_plus4_f       = pc_f + PC_STEP;
  assign redirect_pending = pending_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_adel_f = (pc_f[1:0] != 2'b00);
`endif

  // next-PC selection, redirect buffering and delay-slot tagging
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_f          <= RESET_PC;
      pending_valid <= 1'b0;
      pending_pc    <= 32'd0;
      is_ds_d       <= 1'b0;
    end else if (flush_exc) begin
      pc_f          <= exc_pc;
      pending_valid <= 1'b0;
      is_ds_d       <= 1'b0;
    end else begin
      if (redir_req && !stall_f) begin
        pc_f          <= target;
        pending_valid <= 1'b0;
      end else if (redir_req) begin
        pending_pc    <= target;
        pending_valid <= 1'b1;
      end else if (pending_valid && !stall_f) begin
        pc_f          <= pending_pc;
        pending_valid <= 1'b0;
      end else if (!stall_f) begin
        pc_f <= pc_f + PC_STEP;
      end
      if (!stall_d) begin
        is_ds_d <= is_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed vector table plus randomized run against a queue-based model.
// Define FETCH_ALIGN_CHECK_EN to also check fetch_adel_f.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_f, stall_d, flush_exc;
  logic [31:0] exc_pc;
  logic        branch_d, branch_taken_d, jump_d, jr_d;
  logic [31:0] pc_plus4_d;
  logic [15:0] imm_d;
  logic [25:0] instr_index_d;
  logic [31:0] rs_val_d;
  logic [31:0] pc_f, pc_plus4_f;
  logic        redirect_pending, is_ds_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_adel_f;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .clk              (clk),
    .resetn           (resetn),
    .stall_f          (stall_f),
    .stall_d          (stall_d),
    .flush_exc        (flush_exc),
    .exc_pc           (exc_pc),
    .branch_d         (branch_d),
    .branch_taken_d   (branch_taken_d),
    .jump_d           (jump_d),
    .jr_d             (jr_d),
    .pc_plus4_d       (pc_plus4_d),
    .imm_d            (imm_d),
    .instr_index_d    (instr_index_d),
    .rs_val_d         (rs_val_d),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_adel_f     (fetch_adel_f),
`endif
    .pc_f             (pc_f),
    .pc_plus4_f       (pc_plus4_f),
    .redirect_pending (redirect_pending),
    .is_ds_d          (is_ds_d)
  );

  typedef struct {
    logic        rst_n;
    logic        sf;
    logic        sd;
    logic        fl;
    logic [31:0] exc;
    logic        br;
    logic        tk;
    logic        j;
    logic        jr;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] e_pc;
    logic        e_pend;
    logic        e_ds;
  } vec_t;

  vec_t vecs[20];

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic        m_ds;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc,
                           input logic epend, input logic eds);
    chk({tag, ".pc_f"}, pc_f, epc);
    chk({tag, ".pc_plus4_f"}, pc_plus4_f, epc + 32'd4);
    chk({tag, ".pending"}, {31'd0, redirect_pending}, {31'd0, epend});
    chk({tag, ".is_ds_d"}, {31'd0, is_ds_d}, {31'd0, eds});
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, ".adel"}, {31'd0, fetch_adel_f},
        {31'd0, (epc % 4) != 0});
`endif
  endtask

  task automatic drive(input vec_t v);
    resetn         = v.rst_n;
    stall_f        = v.sf;
    stall_d        = v.sd;
    flush_exc      = v.fl;
    exc_pc         = v.exc;
    branch_d       = v.br;
    branch_taken_d = v.tk;
    jump_d         = v.j;
    jr_d           = v.jr;
    pc_plus4_d     = v.pc4;
    imm_d          = v.imm;
    instr_index_d  = v.idx;
    rs_val_d       = v.rs;
  endtask

  // reference model: applies the architectural rules directly
  task automatic model_step(input vec_t v);
    logic [31:0] tgt;
    logic        req;
    int signed   off;
    off = int'($signed(v.imm)) * 4;
    if (v.jr)
      tgt = v.rs;
    else if (v.j)
      tgt = (v.pc4 & 32'hF000_0000) + ({6'd0, v.idx} * 4);
    else
      tgt = v.pc4 + 32'(off);
    req = !v.sd && (v.jr || v.j || (v.br && v.tk));
    if (!v.rst_n) begin
      m_pc = 32'hBFC0_0000;
      m_pend.delete();
      m_ds = 1'b0;
    end else if (v.fl) begin
      m_pc = v.exc;
      m_pend.delete();
      m_ds = 1'b0;
    end else begin
      if (req && v.sf) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end else if (req) begin
        m_pc = tgt;
        m_pend.delete();
      end else if (m_pend.size() != 0 && !v.sf) begin
        m_pc = m_pend.pop_front();
      end else if (!v.sf) begin
        m_pc = m_pc + 32'd4;
      end
      if (!v.sd) m_ds = v.br || v.j || v.jr;
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.rst_n = ($urandom_range(0, 49) != 0);
    v.sf    = ($urandom_range(0, 2) == 0);
    v.sd    = ($urandom_range(0, 3) == 0);
    v.fl    = ($urandom_range(0, 19) == 0);
    v.exc   = ($urandom_range(0, 1) != 0) ? 32'hBFC0_0380 : $urandom;
    v.br    = ($urandom_range(0, 3) == 0);
    v.tk    = $urandom_range(0, 1) != 0;
    v.j     = ($urandom_range(0, 7) == 0);
    v.jr    = ($urandom_range(0, 7) == 0);
    v.pc4   = $urandom;
    v.imm   = 16'($urandom);
    v.idx   = 26'($urandom);
    v.rs    = $urandom;
    v.e_pc  = 32'd0;
    v.e_pend = 1'b0;
    v.e_ds  = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t idle;
    idle = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0};

    for (int i = 0; i < 20; i++) vecs[i] = idle;
    // sequential fetch
    vecs[0].e_pc = 32'hBFC0_0004;
    vecs[1].e_pc = 32'hBFC0_0008;
    vecs[2].e_pc = 32'hBFC0_000C;
    // beq taken, fetch free
    vecs[3].br = 1; vecs[3].tk = 1;
    vecs[3].pc4 = 32'hBFC0_0008; vecs[3].imm = 16'h0004;
    vecs[3].e_pc = 32'hBFC0_0018; vecs[3].e_ds = 1;
    vecs[4].e_pc = 32'hBFC0_001C;
    // same branch with fetch stalled two cycles
    vecs[5] = vecs[3]; vecs[5].sf = 1;
    vecs[5].e_pc = 32'hBFC0_001C; vecs[5].e_pend = 1;
    vecs[6] = vecs[5]; vecs[6].sd = 1;
    vecs[7].e_pc = 32'hBFC0_0018;
    // jr then j
    vecs[8].jr = 1; vecs[8].rs = 32'h8000_1230;
    vecs[8].e_pc = 32'h8000_1230; vecs[8].e_ds = 1;
    vecs[9].j = 1; vecs[9].idx = 26'h000_0100;
    vecs[9].pc4 = 32'hBFC0_0010;
    vecs[9].e_pc = 32'hB000_0400; vecs[9].e_ds = 1;
    // buffer a redirect then flush under stall
    vecs[10] = vecs[3]; vecs[10].sf = 1;
    vecs[10].e_pc = 32'hB000_0400; vecs[10].e_pend = 1;
    vecs[11].sf = 1; vecs[11].fl = 1; vecs[11].exc = 32'hBFC0_0380;
    vecs[11].br = 1; vecs[11].tk = 1; vecs[11].pc4 = 32'h1000_0000;
    vecs[11].e_pc = 32'hBFC0_0380;
    // not-taken branch still tags the delay slot
    vecs[12].br = 1; vecs[12].pc4 = 32'h1000_0000;
    vecs[12].e_pc = 32'hBFC0_0384; vecs[12].e_ds = 1;
    // backward branch
    vecs[13].br = 1; vecs[13].tk = 1;
    vecs[13].pc4 = 32'hBFC0_0100; vecs[13].imm = 16'hFFFF;
    vecs[13].e_pc = 32'hBFC0_00FC; vecs[13].e_ds = 1;
    // both stalled with a jr waiting in decode
    vecs[14].sf = 1; vecs[14].sd = 1; vecs[14].jr = 1;
    vecs[14].rs = 32'h4444_0000;
    vecs[14].e_pc = 32'hBFC0_00FC; vecs[14].e_ds = 1;
    // decode stalled: jump ignored, fetch advances
    vecs[15].sd = 1; vecs[15].j = 1;
    vecs[15].e_pc = 32'hBFC0_0100; vecs[15].e_ds = 1;
    // jr beats jump when both raised
    vecs[16].jr = 1; vecs[16].j = 1; vecs[16].rs = 32'h1234_5678;
    vecs[16].idx = 26'h3FF_FFFF;
    vecs[16].e_pc = 32'h1234_5678; vecs[16].e_ds = 1;
    // misaligned jr target loaded as-is
    vecs[17].jr = 1; vecs[17].rs = 32'h8000_0002;
    vecs[17].e_pc = 32'h8000_0002; vecs[17].e_ds = 1;
    vecs[18].sf = 1; vecs[18].sd = 1;
    vecs[18].e_pc = 32'h8000_0002; vecs[18].e_ds = 1;
    // reset during stall
    vecs[19].rst_n = 0; vecs[19].sf = 1; vecs[19].sd = 1;
    vecs[19].e_pc = 32'hBFC0_0000;

    idle.rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'hBFC0_0000, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc,
                vecs[i].e_pend, vecs[i].e_ds);
    end

    // randomized run from a known reset
    m_pc = 32'hBFC0_0000;
    m_pend.delete();
    m_ds = 1'b0;
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v = rand_vec();
      drive(v);
      model_step(v);
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", i), m_pc,
                m_pend.size() != 0, m_ds);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
